// File: rtl/mod_sub_pipe.sv
// mod_sub_pipe: two-stage valid/ready pipelined modular subtractor, r = (a - b) mod (2^N - k)
module mod_sub_pipe #(
  parameter int N    = 7,
  parameter int KMAX = 63
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] k,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] r,
  output logic         err
);
  localparam logic [N:0] kmax_w = (N+1)'(KMAX);
  localparam logic [N:0] two_n  = (N+1)'(1) << N;
  logic         v1, v2, adv1, adv2, b1, e1;
  logic [N-1:0] d1, k1;
  logic [N:0]   d, m;
  assign d         = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
  assign m         = two_n - {1'b0, k};
  assign adv2      = ~v2 | out_ready;
  assign adv1      = ~v1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;
  // Stage 1: raw difference, borrow, per-beat k and operand legality
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      d1 <= '0;
      b1 <= 1'b0;
      k1 <= '0;
      e1 <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        d1 <= d[N-1:0];
        b1 <= ~d[N];
        k1 <= k;
        e1 <= ({1'b0, a} >= m) | ({1'b0, b} >= m) | ({1'b0, k} > kmax_w);
      end
    end
  end
  // Stage 2: on borrow, the wrapped difference already carries +2^N, so subtracting k lands on the residue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2  <= 1'b0;
      r   <= '0;
      err <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        r   <= b1 ? d1 - k1 : d1;
        err <= e1;
      end
    end
  end
endmodule

// File: tb/tb_mod_sub_pipe.sv
// tb_mod_sub_pipe: directed and randomized check of mod_sub_pipe against a modular-arithmetic model
module tb_mod_sub_pipe;
  localparam int N = 7;
  localparam int P = 2 ** N;
  typedef struct { int r; int e; } exp_t;
  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic         in_ready, out_valid, err;
  logic [N-1:0] a = '0, b = '0, k = '0, r;
  int           n_chk = 0, n_fail = 0, cyc = 0, acc_cnt = 0;
  exp_t         exp_q[$];
  int           emit_cyc[$];
  bit           rand_done;
  mod_sub_pipe #(.N(N), .KMAX(63)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .k(k), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(string tag, int obs, int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask
  function automatic exp_t model(int ai, int bi, int ki);
    exp_t x;
    int   m = P - ki;
    x.r = ai >= bi ? ai - bi : (ai - bi + P - ki) & (P - 1);
    x.e = (ai >= m || bi >= m || ki > 63) ? 1 : 0;
    return x;
  endfunction
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int'(a), int'(b), int'(k)));
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        emit_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else begin
          check("r", int'(r), exp_q[0].r);
          check("err", int'(err), exp_q[0].e);
          void'(exp_q.pop_front());
        end
      end
    end
  end
  task automatic send(int ai, int bi, int ki);
    int n = 0;
    a = N'(ai); b = N'(bi); k = N'(ki); in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int r0, acc0;
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_r", int'(r), 0);
    check("rst_err", int'(err), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    a = 7'd10; b = 7'd3; k = 7'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("lat_early_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    check("lat_valid", int'(out_valid), 1);
    check("lat_r", int'(r), 7);
    check("lat_err", int'(err), 0);
    drain();
    emit_cyc.delete();
    send(3, 10, 3);
    send(0, 124, 3);
    send(124, 124, 3);
    drain();
    check("b2b_count", emit_cyc.size(), 3);
    if (emit_cyc.size() == 3) begin
      check("b2b_gap1", emit_cyc[1] - emit_cyc[0], 1);
      check("b2b_gap2", emit_cyc[2] - emit_cyc[1], 1);
    end
    send(5, 9, 0);
    send(5, 9, 3);
    drain();
    acc0 = acc_cnt;
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 4; i++) send(20 + i, 30, 3);
      begin
        repeat (3) @(negedge clk);
        r0 = int'(r);
        repeat (2) @(negedge clk);
        check("stall_accepted", acc_cnt - acc0, 2);
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_out_valid", int'(out_valid), 1);
        check("stall_r_stable", int'(r), r0);
        check("stall_r_value", int'(r), model(20, 30, 3).r);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_total", acc_cnt - acc0, 4);
    send(126, 1, 3);
    send(10, 3, 3);
    drain();
    send(40, 50, 3);
    send(60, 2, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_r", int'(r), 0);
    check("mid_rst_err", int'(err), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 send(2, 100, 3);
    drain();
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          int ki = $urandom_range(0, 63);
          int m  = P - ki;
          if ($urandom_range(0, 7) == 0) send($urandom_range(0, P - 1), $urandom_range(0, P - 1), $urandom_range(0, P - 1));
          else send($urandom_range(0, m - 1), $urandom_range(0, m - 1), ki);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      while (!rand_done) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(0, 2) != 0);
      end
    join
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
